// File: rtl/four_to_one_collector.sv
// Four-lane to one-stream collector with round-robin grant and a one-deep
// registered output stage; each word is tagged with its source lane code.
module four_to_one_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  input  logic             v4,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic             r4,
  output logic [WIDTH-1:0] out,
  output logic             out_s1,
  output logic             out_s0,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       tag_q, tag_d;
  logic [1:0]       last_q, last_d;
  logic             valid_q, valid_d;

  logic [3:0]       v_vec;
  logic [3:0]       gnt;
  logic [3:0]       rdy;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic             gvalid;
  logic             free;
  logic [WIDTH-1:0] gdata;

  assign v_vec = {v4, v3, v2, v1};
  assign free  = ~valid_q | out_ready;

  // Search starts one past the last served lane; the 2-bit add wraps 4 -> 1.
  always_comb begin
    gvalid = 1'b0;
    gidx   = last_q;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!gvalid && v_vec[idx]) begin
        gvalid = 1'b1;
        gidx   = idx;
      end
    end
  end

  assign gnt = gvalid ? (4'b0001 << gidx) : 4'b0000;
  assign rdy = gnt & {4{free}};
  assign {r4, r3, r2, r1} = rdy;

  always_comb begin
    case (gidx)
      2'd0:    gdata = a1;
      2'd1:    gdata = a2;
      2'd2:    gdata = a3;
      default: gdata = a4;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (|rdy) begin
      out_d   = gdata;
      tag_d   = gidx;
      valid_d = 1'b1;
      last_d  = gidx;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      tag_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      out_q   <= out_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out       = out_q;
  assign out_s1    = tag_q[1];
  assign out_s0    = tag_q[0];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_four_to_one_collector.sv
// Bench for four_to_one_collector: directed scenarios plus randomized traffic,
// checked against a lane-level round-robin reference model.
module tb_four_to_one_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a1, a2, a3, a4;
  logic       v1, v2, v3, v4;
  logic       r1, r2, r3, r4;
  logic [7:0] out;
  logic       out_s1, out_s0, out_valid;
  logic       out_ready;

  four_to_one_collector #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .out(out), .out_s1(out_s1), .out_s0(out_s0), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus per lane, index 1..4
  logic [7:0] a_t [1:4];
  logic       v_t [1:4];

  // reference model: lane numbers 1..4, tag = lane-1
  int         m_last;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_tag;
  logic       r_prev [1:4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    a1 = a_t[1]; a2 = a_t[2]; a3 = a_t[3]; a4 = a_t[4];
    v1 = v_t[1]; v2 = v_t[2]; v3 = v_t[3]; v4 = v_t[4];
  endtask

  function automatic int model_grant();
    int l;
    for (int k = 1; k <= 4; k++) begin
      l = ((m_last + k - 1) % 4) + 1;
      if (v_t[l]) return l;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_last  = 4;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_tag   = 0;
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic step();
    int   g;
    logic fr;
    logic [3:0] r_obs, r_exp;
    drive();
    #1;
    g  = model_grant();
    fr = !m_valid || out_ready;
    r_exp = (fr && g != 0) ? 4'(1 << (g - 1)) : 4'b0;
    r_obs = {r4, r3, r2, r1};
    chk("lane_ready", 32'(r_obs), 32'(r_exp));
    for (int i = 1; i <= 4; i++) r_prev[i] = r_exp[i-1];
    @(posedge clk);
    if (fr && g != 0) begin
      m_valid = 1'b1;
      m_data  = a_t[g];
      m_tag   = g - 1;
      m_last  = g;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out), 32'(m_data));
      chk("out_tag", 32'({out_s1, out_s0}), 32'(m_tag));
    end
    @(negedge clk);
  endtask

  // Asserts rst between edges and checks that the stage clears with no clock edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_valid", 32'(out_valid), 32'(0));
    chk("rst_async_data", 32'(out), 32'(0));
    chk("rst_async_tag", 32'({out_s1, out_s0}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_all(input logic v, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
    a_t[1] = b1; a_t[2] = b2; a_t[3] = b3; a_t[4] = b4;
    for (int i = 1; i <= 4; i++) v_t[i] = v;
  endtask

  initial begin
    model_reset();
    for (int i = 1; i <= 4; i++) r_prev[i] = 1'b0;
    set_all(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b1;
    drive();
    #3;
    chk("reset_valid", 32'(out_valid), 32'(0));
    chk("reset_data", 32'(out), 32'(0));
    chk("reset_tag", 32'({out_s1, out_s0}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // round-robin, all lanes valid: 1,2,3,4 twice with no gaps
    set_all(1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    chk("first_word", 32'(out), 32'h11);
    chk("first_tag", 32'({out_s1, out_s0}), 32'(0));
    for (int i = 0; i < 7; i++) step();
    chk("rr_last_tag", 32'({out_s1, out_s0}), 32'(3));

    // mid-stream async reset, then first grant to lane1
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    async_reset();
    step();
    chk("post_rst_word", 32'(out), 32'h11);

    // sparse lanes 2 and 4 after reset
    async_reset();
    set_all(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
    v_t[2] = 1'b1; v_t[4] = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // backpressure: hold 0xA5/lane3 while lane1 waits
    set_all(1'b0, 8'h5A, 8'h00, 8'hA5, 8'h00);
    v_t[3] = 1'b1;
    step();
    v_t[3] = 1'b0; v_t[1] = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_hold_data", 32'(out), 32'hA5);
    chk("bp_hold_tag", 32'({out_s1, out_s0}), 32'(2));
    out_ready = 1'b1;
    step();
    chk("bp_reload_data", 32'(out), 32'h5A);
    chk("bp_reload_valid", 32'(out_valid), 32'(1));

    // idle drain, then resume from the lane after lane1
    v_t[1] = 1'b0;
    step();
    step();
    set_all(1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    chk("drain_resume_tag", 32'({out_s1, out_s0}), 32'(1));

    // demux loopback: select code steers a=1 onto one lane
    for (int s = 0; s < 4; s++) begin
      set_all(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      v_t[s+1] = 1'b1;
      a_t[s+1] = 8'h01;
      step();
      chk("demux_tag", 32'({out_s1, out_s0}), 32'(s));
    end

    // randomized traffic; a waiting lane keeps its word until it is taken
    set_all(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 400; n++) begin
      for (int i = 1; i <= 4; i++) begin
        if (!(v_t[i] && !r_prev[i]) || r_prev[i]) begin
          v_t[i] = ($urandom_range(0, 99) < 55);
          a_t[i] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        for (int i = 1; i <= 4; i++) r_prev[i] = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
